// File: rtl/reg_file_sb_pkg.sv
// Shared defaults and width helpers for the scoreboarded register file.
package reg_file_pkg;

    localparam int DEF_W = 8;
    localparam int DEF_N = 8;

    // Width needed to hold a pending count of 0..n inclusive.
    function automatic int count_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/reg_file_sb_if.sv
// Write, reserve and read signals of the register file, grouped for master/slave use.
interface reg_file_sb_if
    import reg_file_pkg::*;
#(
    parameter int W = DEF_W,
    parameter int N = DEF_N
);
    localparam int AW = $clog2(N);
    localparam int CW = count_width(N);

    logic [W-1:0]  IN;
    logic [AW-1:0] INADDRESS;
    logic          WRITE;
    logic [W-1:0]  LDIN;
    logic [AW-1:0] LDADDRESS;
    logic          LDWRITE;
    logic          RESERVE;
    logic [AW-1:0] RESADDRESS;
    logic [AW-1:0] OUT1ADDRESS;
    logic [AW-1:0] OUT2ADDRESS;
    logic [W-1:0]  OUT1;
    logic [W-1:0]  OUT2;
    logic          BUSY1;
    logic          BUSY2;
    logic [CW-1:0] PENDCOUNT;

    modport master (
        output IN, INADDRESS, WRITE, LDIN, LDADDRESS, LDWRITE,
               RESERVE, RESADDRESS, OUT1ADDRESS, OUT2ADDRESS,
        input  OUT1, OUT2, BUSY1, BUSY2, PENDCOUNT
    );

    modport slave (
        input  IN, INADDRESS, WRITE, LDIN, LDADDRESS, LDWRITE,
               RESERVE, RESADDRESS, OUT1ADDRESS, OUT2ADDRESS,
        output OUT1, OUT2, BUSY1, BUSY2, PENDCOUNT
    );
endinterface

// File: rtl/reg_file_sb_scoreboard.sv
// Pending bits for outstanding loads: same-edge priority, BUSY flags and pending count.
module reg_file_scoreboard
    import reg_file_pkg::*;
#(
    parameter  int N  = DEF_N,
    localparam int AW = $clog2(N),
    localparam int CW = count_width(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          write,
    input  logic [AW-1:0] in_addr,
    input  logic          ldwrite,
    input  logic [AW-1:0] ld_addr,
    input  logic          reserve,
    input  logic [AW-1:0] res_addr,
    input  logic [AW-1:0] out1_addr,
    input  logic [AW-1:0] out2_addr,
    output logic          ld_hit,
    output logic          ld_commit,
    output logic          busy1,
    output logic          busy2,
    output logic [CW-1:0] pend_count
);
    logic [N-1:0]  pend_r;
    logic [N-1:0]  pend_next_s;
    logic [CW-1:0] count_next_s;
    logic [CW-1:0] count_r;

    // A load only lands on a register still waiting for it, and never over an ALU write.
    assign ld_hit    = ldwrite & pend_r[ld_addr];
    assign ld_commit = ld_hit & ~(write && (in_addr == ld_addr));

    assign busy1 = ~rst & pend_r[out1_addr]
                 & ~(write && (in_addr == out1_addr))
                 & ~(ld_hit && (ld_addr == out1_addr));
    assign busy2 = ~rst & pend_r[out2_addr]
                 & ~(write && (in_addr == out2_addr))
                 & ~(ld_hit && (ld_addr == out2_addr));

    assign pend_count = count_r;

    // Next pending state: a reserve outranks any clearing write on the same register.
    always_comb begin
        pend_next_s  = pend_r;
        count_next_s = {CW{1'b0}};
        for (int i = 0; i < N; i++) begin
            pend_next_s[i] = (reserve && (res_addr == AW'(i))) ? 1'b1 :
                             ((write && (in_addr == AW'(i))) ||
                              (ld_hit && (ld_addr == AW'(i)))) ? 1'b0 : pend_r[i];
            count_next_s   = count_next_s + CW'(pend_next_s[i]);
        end
    end

    // Pending bits and their population count move together on each edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_r  <= {N{1'b0}};
            count_r <= {CW{1'b0}};
        end else begin
            pend_r  <= pend_next_s;
            count_r <= count_next_s;
        end
    end
endmodule

// File: rtl/reg_file_sb.sv
// Two-read, two-write register file with load scoreboard and write-first read bypass.
module reg_file_sb
    import reg_file_pkg::*;
#(
    parameter int W = DEF_W,
    parameter int N = DEF_N
) (
    input  logic         CLK,
    input  logic         RESET,
    reg_file_sb_if.slave bus
);
    localparam int AW = $clog2(N);

    logic [W-1:0] mem_r [N];
    logic         ld_hit_s;
    logic         ld_commit_s;
    logic [W-1:0] out1_s;
    logic [W-1:0] out2_s;

    reg_file_scoreboard #(.N(N)) u_sb (
        .clk        (CLK),
        .rst        (RESET),
        .write      (bus.WRITE),
        .in_addr    (bus.INADDRESS),
        .ldwrite    (bus.LDWRITE),
        .ld_addr    (bus.LDADDRESS),
        .reserve    (bus.RESERVE),
        .res_addr   (bus.RESADDRESS),
        .out1_addr  (bus.OUT1ADDRESS),
        .out2_addr  (bus.OUT2ADDRESS),
        .ld_hit     (ld_hit_s),
        .ld_commit  (ld_commit_s),
        .busy1      (bus.BUSY1),
        .busy2      (bus.BUSY2),
        .pend_count (bus.PENDCOUNT)
    );

    // Data array; ld_commit already excludes a same-address ALU write.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < N; i++) begin
                mem_r[i] <= {W{1'b0}};
            end
        end else begin
            if (bus.WRITE) begin
                mem_r[bus.INADDRESS] <= bus.IN;
            end
            if (ld_commit_s) begin
                mem_r[bus.LDADDRESS] <= bus.LDIN;
            end
        end
    end

    // Read port 1: ALU data, then a live load, then stored value.
    always_comb begin
        out1_s = {W{1'b0}};
        if (RESET) begin
            out1_s = {W{1'b0}};
        end else if (bus.WRITE && (bus.INADDRESS == bus.OUT1ADDRESS)) begin
            out1_s = bus.IN;
        end else if (ld_hit_s && (bus.LDADDRESS == bus.OUT1ADDRESS)) begin
            out1_s = bus.LDIN;
        end else begin
            out1_s = mem_r[bus.OUT1ADDRESS];
        end
    end

    // Read port 2: same bypass order as port 1.
    always_comb begin
        out2_s = {W{1'b0}};
        if (RESET) begin
            out2_s = {W{1'b0}};
        end else if (bus.WRITE && (bus.INADDRESS == bus.OUT2ADDRESS)) begin
            out2_s = bus.IN;
        end else if (ld_hit_s && (bus.LDADDRESS == bus.OUT2ADDRESS)) begin
            out2_s = bus.LDIN;
        end else begin
            out2_s = mem_r[bus.OUT2ADDRESS];
        end
    end

    assign bus.OUT1 = out1_s;
    assign bus.OUT2 = out2_s;
endmodule
